// File: rtl/pong_game_state.sv
// rtl/pong_game_state.sv - per-frame Pong engine: ball, paddles, scores, serve/play/game-over state
// Everything advances only on frame_tick; outputs are registers so the renderer never sees a half-updated frame.
module pong_game_state #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_L_X   = 16,
  parameter int PADDLE_R_X   = 616,
  parameter int PADDLE_STEP  = 4,
  parameter int BALL_SPEED   = 2,
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_l_up,
  input  logic       btn_l_dn,
  input  logic       btn_r_up,
  input  logic       btn_r_dn,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] paddle_l_y,
  output logic [9:0] paddle_r_y,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [1:0] game_state,
  output logic       update_done
);

  localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [9:0]  BALL_X0   = 10'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0]  BALL_Y0   = 10'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0]  PADDLE_Y0 = 10'((V_ACTIVE - PADDLE_H) / 2);
  localparam logic [9:0]  X_HIT_L   = 10'(PADDLE_L_X + PADDLE_W);
  localparam logic [9:0]  X_HIT_R   = 10'(PADDLE_R_X - BALL_SIZE);
  localparam logic [9:0]  Y_MAX10   = 10'(V_ACTIVE - BALL_SIZE);
  localparam logic [9:0]  P_MAX10   = 10'(V_ACTIVE - PADDLE_H);
  localparam logic [10:0] SPD       = 11'(BALL_SPEED);
  localparam logic [10:0] SIZE      = 11'(BALL_SIZE);
  localparam logic [10:0] PH        = 11'(PADDLE_H);
  localparam logic [10:0] STEP      = 11'(PADDLE_STEP);
  localparam logic [10:0] X_MAX     = 11'(H_ACTIVE - BALL_SIZE);
  localparam logic [10:0] Y_MAX     = 11'(V_ACTIVE - BALL_SIZE);
  localparam logic [10:0] P_MAX     = 11'(V_ACTIVE - PADDLE_H);
  localparam logic [10:0] L_FACE    = 11'(PADDLE_L_X + PADDLE_W);
  localparam logic [10:0] R_FACE    = 11'(PADDLE_R_X);
  localparam logic [3:0]  WIN       = 4'(WIN_SCORE);

  typedef enum logic [1:0] {SERVE = 2'b00, PLAY = 2'b01, GAMEOVER = 2'b10} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] serve_cnt, serve_cnt_n;
  logic             dx_right, dx_right_n, dy_down, dy_down_n;
  logic [9:0]       ball_x_n, ball_y_n, paddle_l_n, paddle_r_n;
  logic [3:0]       score_l_n, score_r_n, score_l_inc, score_r_inc;
  logic [3:0]       btn_meta, btn_sync;
  logic             l_up, l_dn, r_up, r_dn;
  logic [10:0]      bx, by, pl, pr;
  logic             overlap_l, overlap_r, hit_l, hit_r, miss_l, miss_r;

  assign {l_up, l_dn, r_up, r_dn} = btn_sync;
  assign game_state  = state;
  assign bx          = {1'b0, ball_x};
  assign by          = {1'b0, ball_y};
  assign pl          = {1'b0, paddle_l_y};
  assign pr          = {1'b0, paddle_r_y};
  assign score_l_inc = score_l + 4'd1;
  assign score_r_inc = score_r + 4'd1;

  // Collision tests use the paddle positions from before this frame's move.
  assign overlap_l = (by + SIZE > pl) && (by < pl + PH);
  assign overlap_r = (by + SIZE > pr) && (by < pr + PH);
  assign hit_l  = !dx_right && (bx >= L_FACE) && (bx < L_FACE + SPD) && overlap_l;
  assign hit_r  = dx_right && (bx + SIZE <= R_FACE) && (bx + SPD + SIZE > R_FACE) && overlap_r;
  assign miss_l = !dx_right && (bx < SPD);
  assign miss_r = dx_right && (bx + SPD > X_MAX);

  function automatic logic [9:0] paddle_move(input logic [9:0] y, input logic up, input logic dn);
    if (up && !dn) return ({1'b0, y} < STEP) ? 10'd0 : y - 10'(PADDLE_STEP);
    if (dn && !up) return ({1'b0, y} + STEP > P_MAX) ? P_MAX10 : y + 10'(PADDLE_STEP);
    return y;
  endfunction

  always_comb begin
    state_n     = state;
    serve_cnt_n = serve_cnt;
    dx_right_n  = dx_right;
    dy_down_n   = dy_down;
    ball_x_n    = ball_x;
    ball_y_n    = ball_y;
    paddle_l_n  = paddle_l_y;
    paddle_r_n  = paddle_r_y;
    score_l_n   = score_l;
    score_r_n   = score_r;
    case (state)
      SERVE: begin
        paddle_l_n = paddle_move(paddle_l_y, l_up, l_dn);
        paddle_r_n = paddle_move(paddle_r_y, r_up, r_dn);
        if (serve_cnt == SERVE_LAST) begin
          state_n     = PLAY;
          serve_cnt_n = '0;
        end else begin
          serve_cnt_n = serve_cnt + CNT_W'(1);
        end
      end
      PLAY: begin
        paddle_l_n = paddle_move(paddle_l_y, l_up, l_dn);
        paddle_r_n = paddle_move(paddle_r_y, r_up, r_dn);
        if (!dy_down) begin
          if (by < SPD) begin
            ball_y_n  = 10'd0;
            dy_down_n = 1'b1;
          end else begin
            ball_y_n = ball_y - 10'(BALL_SPEED);
          end
        end else if (by + SPD > Y_MAX) begin
          ball_y_n  = Y_MAX10;
          dy_down_n = 1'b0;
        end else begin
          ball_y_n = ball_y + 10'(BALL_SPEED);
        end
        // A miss recentres both axes and serves toward the player who conceded.
        if (hit_l) begin
          ball_x_n   = X_HIT_L;
          dx_right_n = 1'b1;
        end else if (hit_r) begin
          ball_x_n   = X_HIT_R;
          dx_right_n = 1'b0;
        end else if (miss_l) begin
          score_r_n  = score_r_inc;
          ball_x_n   = BALL_X0;
          ball_y_n   = BALL_Y0;
          dx_right_n = 1'b0;
          state_n    = (score_r_inc == WIN) ? GAMEOVER : SERVE;
        end else if (miss_r) begin
          score_l_n  = score_l_inc;
          ball_x_n   = BALL_X0;
          ball_y_n   = BALL_Y0;
          dx_right_n = 1'b1;
          state_n    = (score_l_inc == WIN) ? GAMEOVER : SERVE;
        end else begin
          ball_x_n = dx_right ? ball_x + 10'(BALL_SPEED) : ball_x - 10'(BALL_SPEED);
        end
      end
      GAMEOVER: begin
        if (|btn_sync) begin
          score_l_n   = 4'd0;
          score_r_n   = 4'd0;
          ball_x_n    = BALL_X0;
          ball_y_n    = BALL_Y0;
          paddle_l_n  = PADDLE_Y0;
          paddle_r_n  = PADDLE_Y0;
          serve_cnt_n = '0;
          state_n     = SERVE;
        end
      end
      default: state_n = SERVE;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      btn_meta    <= 4'd0;
      btn_sync    <= 4'd0;
      state       <= SERVE;
      serve_cnt   <= '0;
      dx_right    <= 1'b1;
      dy_down     <= 1'b1;
      ball_x      <= BALL_X0;
      ball_y      <= BALL_Y0;
      paddle_l_y  <= PADDLE_Y0;
      paddle_r_y  <= PADDLE_Y0;
      score_l     <= 4'd0;
      score_r     <= 4'd0;
      update_done <= 1'b0;
    end else begin
      btn_meta    <= {btn_l_up, btn_l_dn, btn_r_up, btn_r_dn};
      btn_sync    <= btn_meta;
      update_done <= frame_tick;
      if (frame_tick) begin
        state      <= state_n;
        serve_cnt  <= serve_cnt_n;
        dx_right   <= dx_right_n;
        dy_down    <= dy_down_n;
        ball_x     <= ball_x_n;
        ball_y     <= ball_y_n;
        paddle_l_y <= paddle_l_n;
        paddle_r_y <= paddle_r_n;
        score_l    <= score_l_n;
        score_r    <= score_r_n;
      end
    end
  end

endmodule

// File: tb/tb_pong_game_state.sv
// tb/tb_pong_game_state.sv - directed bench for pong_game_state following one full game
// Play-tick index p counts PLAY frames of the current rally; expected coordinates are hand-derived from it.
module tb_pong_game_state;

  logic       vga_clk = 1'b0;
  logic       reset, frame_tick;
  logic       btn_l_up, btn_l_dn, btn_r_up, btn_r_dn;
  logic [9:0] ball_x, ball_y, paddle_l_y, paddle_r_y;
  logic [3:0] score_l, score_r;
  logic [1:0] game_state;
  logic       update_done;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 vga_clk = ~vga_clk;

  pong_game_state #(.SERVE_FRAMES(60), .WIN_SCORE(9)) dut (
    .vga_clk(vga_clk), .reset(reset), .frame_tick(frame_tick),
    .btn_l_up(btn_l_up), .btn_l_dn(btn_l_dn), .btn_r_up(btn_r_up), .btn_r_dn(btn_r_dn),
    .ball_x(ball_x), .ball_y(ball_y), .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
    .score_l(score_l), .score_r(score_r), .game_state(game_state), .update_done(update_done)
  );

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge vga_clk);
    frame_tick = 1'b0;
    @(negedge vga_clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_btn(input logic lu, input logic ld, input logic ru, input logic rd);
    btn_l_up = lu; btn_l_dn = ld; btn_r_up = ru; btn_r_dn = rd;
    repeat (3) @(negedge vga_clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_tick = 1'b0;
    btn_l_up = 1'b0; btn_l_dn = 1'b0; btn_r_up = 1'b0; btn_r_dn = 1'b0;
    repeat (3) @(negedge vga_clk);
    n_checks++; if (ball_x !== 10'd316) begin n_fail++; $display("FAIL reset_ball_x: got %0d want 316", ball_x); end
    n_checks++; if (ball_y !== 10'd236) begin n_fail++; $display("FAIL reset_ball_y: got %0d want 236", ball_y); end
    n_checks++; if (paddle_l_y !== 10'd208 || paddle_r_y !== 10'd208) begin n_fail++; $display("FAIL reset_paddles: got %0d/%0d want 208/208", paddle_l_y, paddle_r_y); end
    n_checks++; if (score_l !== 4'd0 || score_r !== 4'd0 || game_state !== 2'b00) begin n_fail++; $display("FAIL reset_score_state: got %0d/%0d/%0d want 0/0/0", score_l, score_r, game_state); end
    n_checks++; if (update_done !== 1'b0) begin n_fail++; $display("FAIL reset_update_done: got %0d want 0", update_done); end
    reset = 1'b0;
    @(negedge vga_clk);
  endtask

  task automatic test_serve_and_paddles();
    set_btn(1, 0, 0, 1);
    ticks(51);
    n_checks++; if (paddle_l_y !== 10'd4 || paddle_r_y !== 10'd412) begin n_fail++; $display("FAIL paddle_tick51: got %0d/%0d want 4/412", paddle_l_y, paddle_r_y); end
    n_checks++; if (ball_x !== 10'd316 || game_state !== 2'b00) begin n_fail++; $display("FAIL serve_hold: got x=%0d st=%0d want 316/0", ball_x, game_state); end
    tick();
    n_checks++; if (paddle_l_y !== 10'd0 || paddle_r_y !== 10'd416) begin n_fail++; $display("FAIL paddle_tick52: got %0d/%0d want 0/416", paddle_l_y, paddle_r_y); end
    ticks(7);
    n_checks++; if (paddle_l_y !== 10'd0 || paddle_r_y !== 10'd416) begin n_fail++; $display("FAIL paddle_clamp: got %0d/%0d want 0/416", paddle_l_y, paddle_r_y); end
    n_checks++; if (game_state !== 2'b00) begin n_fail++; $display("FAIL serve_tick59: got %0d want 0", game_state); end
    frame_tick = 1'b1;
    @(negedge vga_clk);
    frame_tick = 1'b0;
    n_checks++; if (game_state !== 2'b01) begin n_fail++; $display("FAIL serve_to_play: got %0d want 1", game_state); end
    n_checks++; if (update_done !== 1'b1) begin n_fail++; $display("FAIL update_done_pulse: got %0d want 1", update_done); end
    @(negedge vga_clk);
    n_checks++; if (update_done !== 1'b0) begin n_fail++; $display("FAIL update_done_clear: got %0d want 0", update_done); end
    tick();
    n_checks++; if (ball_x !== 10'd318 || ball_y !== 10'd238) begin n_fail++; $display("FAIL first_move: got %0d,%0d want 318,238", ball_x, ball_y); end
  endtask

  task automatic test_both_buttons();
    set_btn(1, 1, 1, 1);
    tick();
    n_checks++; if (paddle_l_y !== 10'd0 || paddle_r_y !== 10'd416) begin n_fail++; $display("FAIL both_buttons_hold: got %0d/%0d want 0/416", paddle_l_y, paddle_r_y); end
    n_checks++; if (ball_x !== 10'd320 || ball_y !== 10'd240) begin n_fail++; $display("FAIL second_move: got %0d,%0d want 320,240", ball_x, ball_y); end
    set_btn(0, 0, 0, 0);
  endtask

  task automatic test_bottom_bounce();
    ticks(115);
    n_checks++; if (ball_x !== 10'd550 || ball_y !== 10'd470) begin n_fail++; $display("FAIL p117: got %0d,%0d want 550,470", ball_x, ball_y); end
    tick();
    n_checks++; if (ball_y !== 10'd472) begin n_fail++; $display("FAIL p118_y: got %0d want 472", ball_y); end
    tick();
    n_checks++; if (ball_y !== 10'd472) begin n_fail++; $display("FAIL bottom_clamp: got %0d want 472", ball_y); end
    tick();
    n_checks++; if (ball_x !== 10'd556 || ball_y !== 10'd470) begin n_fail++; $display("FAIL bottom_rebound: got %0d,%0d want 556,470", ball_x, ball_y); end
  endtask

  task automatic test_right_paddle_hit();
    ticks(26);
    n_checks++; if (ball_x !== 10'd608 || ball_y !== 10'd418) begin n_fail++; $display("FAIL p146: got %0d,%0d want 608,418", ball_x, ball_y); end
    tick();
    n_checks++; if (ball_x !== 10'd608 || ball_y !== 10'd416) begin n_fail++; $display("FAIL right_hit: got %0d,%0d want 608,416", ball_x, ball_y); end
    tick();
    n_checks++; if (ball_x !== 10'd606) begin n_fail++; $display("FAIL right_rebound: got %0d want 606", ball_x); end
  endtask

  task automatic test_paddle_moves();
    set_btn(0, 1, 1, 0);
    ticks(52);
    n_checks++; if (paddle_l_y !== 10'd208 || paddle_r_y !== 10'd208) begin n_fail++; $display("FAIL paddles_mid: got %0d/%0d want 208/208", paddle_l_y, paddle_r_y); end
    set_btn(0, 1, 0, 0);
    ticks(56);
    n_checks++; if (paddle_l_y !== 10'd416 || paddle_r_y !== 10'd208) begin n_fail++; $display("FAIL paddle_down_clamp: got %0d/%0d want 416/208", paddle_l_y, paddle_r_y); end
    n_checks++; if (ball_x !== 10'd390 || ball_y !== 10'd198) begin n_fail++; $display("FAIL p256: got %0d,%0d want 390,198", ball_x, ball_y); end
    set_btn(0, 0, 0, 0);
  endtask

  task automatic test_top_bounce();
    ticks(98);
    n_checks++; if (ball_y !== 10'd2) begin n_fail++; $display("FAIL p354_y: got %0d want 2", ball_y); end
    tick();
    n_checks++; if (ball_y !== 10'd0) begin n_fail++; $display("FAIL top_reach: got %0d want 0", ball_y); end
    tick();
    n_checks++; if (ball_y !== 10'd0) begin n_fail++; $display("FAIL top_clamp: got %0d want 0", ball_y); end
    tick();
    n_checks++; if (ball_x !== 10'd188 || ball_y !== 10'd2) begin n_fail++; $display("FAIL top_rebound: got %0d,%0d want 188,2", ball_x, ball_y); end
  endtask

  task automatic test_left_miss();
    ticks(82);
    n_checks++; if (ball_x !== 10'd24 || ball_y !== 10'd166) begin n_fail++; $display("FAIL p439: got %0d,%0d want 24,166", ball_x, ball_y); end
    tick();
    n_checks++; if (ball_x !== 10'd22) begin n_fail++; $display("FAIL left_no_overlap: got %0d want 22", ball_x); end
    ticks(11);
    n_checks++; if (ball_x !== 10'd0 || score_r !== 4'd0) begin n_fail++; $display("FAIL p451: got x=%0d sr=%0d want 0/0", ball_x, score_r); end
    tick();
    n_checks++; if (score_r !== 4'd1 || score_l !== 4'd0 || game_state !== 2'b00) begin n_fail++; $display("FAIL score_r_point: got %0d/%0d st=%0d want 0/1/0", score_l, score_r, game_state); end
    n_checks++; if (ball_x !== 10'd316 || ball_y !== 10'd236) begin n_fail++; $display("FAIL recentre_r: got %0d,%0d want 316,236", ball_x, ball_y); end
  endtask

  task automatic test_left_paddle_hit();
    ticks(60);
    n_checks++; if (game_state !== 2'b01 || ball_x !== 10'd316) begin n_fail++; $display("FAIL serve2: got st=%0d x=%0d want 1/316", game_state, ball_x); end
    ticks(146);
    n_checks++; if (ball_x !== 10'd24 || ball_y !== 10'd418) begin n_fail++; $display("FAIL serve_left_p146: got %0d,%0d want 24,418", ball_x, ball_y); end
    tick();
    n_checks++; if (ball_x !== 10'd24 || ball_y !== 10'd416) begin n_fail++; $display("FAIL left_hit: got %0d,%0d want 24,416", ball_x, ball_y); end
    tick();
    n_checks++; if (ball_x !== 10'd26) begin n_fail++; $display("FAIL left_rebound: got %0d want 26", ball_x); end
  endtask

  task automatic test_right_miss();
    ticks(303);
    n_checks++; if (ball_x !== 10'd632 || game_state !== 2'b01) begin n_fail++; $display("FAIL p451_right: got x=%0d st=%0d want 632/1", ball_x, game_state); end
    tick();
    n_checks++; if (score_l !== 4'd1 || score_r !== 4'd1 || game_state !== 2'b00) begin n_fail++; $display("FAIL score_l_point: got %0d/%0d st=%0d want 1/1/0", score_l, score_r, game_state); end
    n_checks++; if (ball_x !== 10'd316 || ball_y !== 10'd236) begin n_fail++; $display("FAIL recentre_l: got %0d,%0d want 316,236", ball_x, ball_y); end
  endtask

  task automatic test_game_over();
    for (int k = 0; k < 7; k++) begin
      ticks(219);
      n_checks++; if (score_l !== 4'(2 + k) || game_state !== 2'b00) begin n_fail++; $display("FAIL rally_%0d: got sl=%0d st=%0d want %0d/0", k, score_l, game_state, 2 + k); end
    end
    ticks(218);
    n_checks++; if (score_l !== 4'd8 || ball_x !== 10'd632 || game_state !== 2'b01) begin n_fail++; $display("FAIL match_point: got sl=%0d x=%0d st=%0d want 8/632/1", score_l, ball_x, game_state); end
    tick();
    n_checks++; if (score_l !== 4'd9 || game_state !== 2'b10) begin n_fail++; $display("FAIL game_over: got sl=%0d st=%0d want 9/2", score_l, game_state); end
    ticks(5);
    n_checks++; if (score_l !== 4'd9 || game_state !== 2'b10 || ball_x !== 10'd316 || ball_y !== 10'd236) begin n_fail++; $display("FAIL frozen: got sl=%0d st=%0d %0d,%0d want 9/2 316,236", score_l, game_state, ball_x, ball_y); end
    n_checks++; if (paddle_l_y !== 10'd416 || paddle_r_y !== 10'd208) begin n_fail++; $display("FAIL frozen_paddles: got %0d/%0d want 416/208", paddle_l_y, paddle_r_y); end
    set_btn(0, 0, 0, 1);
    tick();
    set_btn(0, 0, 0, 0);
    n_checks++; if (score_l !== 4'd0 || score_r !== 4'd0 || game_state !== 2'b00) begin n_fail++; $display("FAIL restart: got %0d/%0d st=%0d want 0/0/0", score_l, score_r, game_state); end
    n_checks++; if (paddle_l_y !== 10'd208 || paddle_r_y !== 10'd208) begin n_fail++; $display("FAIL restart_paddles: got %0d/%0d want 208/208", paddle_l_y, paddle_r_y); end
  endtask

  task automatic test_back_to_back();
    set_btn(1, 0, 0, 0);
    frame_tick = 1'b1;
    @(negedge vga_clk);
    n_checks++; if (paddle_l_y !== 10'd204 || update_done !== 1'b1) begin n_fail++; $display("FAIL b2b_1: got %0d ud=%0d want 204/1", paddle_l_y, update_done); end
    @(negedge vga_clk);
    n_checks++; if (paddle_l_y !== 10'd200 || update_done !== 1'b1) begin n_fail++; $display("FAIL b2b_2: got %0d ud=%0d want 200/1", paddle_l_y, update_done); end
    @(negedge vga_clk);
    frame_tick = 1'b0;
    n_checks++; if (paddle_l_y !== 10'd196) begin n_fail++; $display("FAIL b2b_3: got %0d want 196", paddle_l_y); end
    @(negedge vga_clk);
    n_checks++; if (paddle_l_y !== 10'd196 || update_done !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %0d ud=%0d want 196/0", paddle_l_y, update_done); end
    set_btn(0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_game();
    ticks(57);
    n_checks++; if (game_state !== 2'b01) begin n_fail++; $display("FAIL serve_after_b2b: got %0d want 1", game_state); end
    ticks(2);
    n_checks++; if (ball_x !== 10'd320) begin n_fail++; $display("FAIL play_after_restart: got %0d want 320", ball_x); end
    reset = 1'b1;
    frame_tick = 1'b1;
    @(negedge vga_clk);
    n_checks++; if (ball_x !== 10'd316 || ball_y !== 10'd236 || game_state !== 2'b00) begin n_fail++; $display("FAIL mid_reset_ball: got %0d,%0d st=%0d want 316,236/0", ball_x, ball_y, game_state); end
    n_checks++; if (paddle_l_y !== 10'd208 || update_done !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ud: got pl=%0d ud=%0d want 208/0", paddle_l_y, update_done); end
    reset = 1'b0;
    frame_tick = 1'b0;
    @(negedge vga_clk);
    n_checks++; if (update_done !== 1'b0) begin n_fail++; $display("FAIL post_reset_ud: got %0d want 0", update_done); end
  endtask

  initial begin
    test_reset();
    test_serve_and_paddles();
    test_both_buttons();
    test_bottom_bounce();
    test_right_paddle_hit();
    test_paddle_moves();
    test_top_bounce();
    test_left_miss();
    test_left_paddle_hit();
    test_right_miss();
    test_game_over();
    test_back_to_back();
    test_reset_mid_game();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pong_game_state.md
# pong_game_state

Per-frame game-logic engine for the Pong display path. It sits directly upstream of the pixel renderer. Once per frame, during vertical blanking, it updates the ball position, both paddle positions, the scores and the serve/play/game-over state. It presents these as stable registered coordinates, so the renderer can compare them against the current pixel position without tearing.

## Interface
Parameters:
- H_ACTIVE, 640: visible pixels per line
- V_ACTIVE, 480: visible lines
- BALL_SIZE, 8: ball is a BALL_SIZE×BALL_SIZE square
- PADDLE_W, 8: paddle width
- PADDLE_H, 64: paddle height
- PADDLE_L_X, 16: left paddle left edge x
- PADDLE_R_X, 616: right paddle left edge x
- PADDLE_STEP, 4: paddle move per frame
- BALL_SPEED, 2: ball move per axis per frame
- WIN_SCORE, 9: score that ends the game (≤15)
- SERVE_FRAMES, 60: frames the ball waits at centre before play

Ports:
- vga_clk  in  1  pixel clock; the only clock
- reset  in  1  synchronous, active-high
- frame_tick  in  1  one-cycle pulse at start of vertical blanking
- btn_l_up, btn_l_dn, btn_r_up, btn_r_dn  in  1 each  debounced, asynchronous paddle buttons
- ball_x, ball_y  out  10 each  ball top-left corner
- paddle_l_y, paddle_r_y  out  10 each  paddle top edge
- score_l, score_r  out  4 each  scores
- game_state  out  2  00 SERVE, 01 PLAY, 10 GAMEOVER
- update_done  out  1  one-cycle pulse after each frame update

## Operation
- Buttons pass through 2-flop synchronizers. Only synchronized values are used.
- All state changes occur only on a vga_clk edge with frame_tick=1. Otherwise every output register holds.
- Reset values:
  - ball_x = (H_ACTIVE−BALL_SIZE)/2 = 316; ball_y = (V_ACTIVE−BALL_SIZE)/2 = 236
  - paddles = (V_ACTIVE−PADDLE_H)/2 = 208
  - scores 0; game_state SERVE; serve counter 0; update_done 0
  - direction dx = right, dy = down
- Paddles (SERVE and PLAY only; held in GAMEOVER), per side:
  - up only: y = max(0, y−PADDLE_STEP)
  - down only: y = min(V_ACTIVE−PADDLE_H, y+PADDLE_STEP)
  - both or neither: hold
- SERVE:
  - Ball held at centre; serve counter increments per tick.
  - When the counter reaches SERVE_FRAMES−1 on a tick: go to PLAY and clear the counter. The ball first moves on the following tick.
- PLAY, per tick:
  - Collisions use the pre-update paddle positions.
  - Vertical and horizontal rules are evaluated independently; both may apply in one tick.
- PLAY vertical:
  - Moving up with ball_y < BALL_SPEED: ball_y = 0, dy = down.
  - Moving down with ball_y+BALL_SPEED > V_ACTIVE−BALL_SIZE: ball_y = 472, dy = up.
  - Otherwise ball_y ± BALL_SPEED.
- PLAY, left paddle:
  - Hit condition: dx left, ball_x ≥ PADDLE_L_X+PADDLE_W (24), ball_x−BALL_SPEED < 24, and vertical overlap (ball_y+BALL_SIZE > paddle_l_y and ball_y < paddle_l_y+PADDLE_H).
  - On hit: ball_x = 24, dx = right.
- PLAY, right paddle:
  - Hit condition: dx right, ball_x+BALL_SIZE ≤ PADDLE_R_X, ball_x+BALL_SPEED+BALL_SIZE > PADDLE_R_X, and vertical overlap with paddle_r_y.
  - On hit: ball_x = PADDLE_R_X−BALL_SIZE = 608, dx = left.
- PLAY, misses (point scored):
  - dx left and ball_x < BALL_SPEED: score_r += 1.
  - dx right and ball_x+BALL_SPEED > H_ACTIVE−BALL_SIZE (632): score_l += 1.
  - After either miss: ball recentred; dx points toward the conceding player; dy unchanged.
  - Next state is GAMEOVER if the new score equals WIN_SCORE, else SERVE.
- Otherwise (PLAY): ball_x ± BALL_SPEED.
- GAMEOVER:
  - Ball and scores frozen.
  - Any synchronized button high on a tick: scores cleared, ball centred, paddles centred, state SERVE.
- Arithmetic: all comparisons are unsigned, with 11-bit intermediates so that neither x+size nor y−speed can wrap.

## Timing
- Registered outputs take new values at the edge that samples frame_tick=1.
- update_done is high for exactly the following cycle.
- Button-to-effect latency: 2 cycles of synchronization, then the next frame_tick.
- Back-to-back frame_ticks (consecutive cycles) are each processed fully.
- reset has priority over frame_tick. Asserting reset mid-game restores all reset values on the next edge, and update_done is 0 during reset.

## Test plan
- Reset with SERVE_FRAMES=60 → outputs at (316,236), paddles 208, scores 0, SERVE. 60 ticks later game_state=01; tick 61 → ball_x=318, ball_y=238.
- Hold btn_l_up for 60 ticks from 208 → paddle_l_y reaches 0 on tick 52 and stays 0. Both buttons held → no change.
- Ball at y=1 moving up, in PLAY → ball_y=0, dy down; next tick ball_y=2.
- Paddle at 208, ball at (25,220) moving left → ball_x=24, dx right. Same ball with paddle at 0 → continues; when ball_x < 2, score_r=1, ball centred, SERVE.
- score_l=8, ball at x=631 moving right with no paddle overlap → score_l=9, GAMEOVER. Ticks without buttons → frozen. btn_r_dn high on a tick → scores 0, SERVE.
- Assert reset in PLAY at the same edge as frame_tick → reset values; update_done stays 0.
